// File: rtl/link_udc_bus_pack_pkg.sv
// Shared definitions for the link-Udc bus packer: phase codes, word widths,
// FSM state type and the bus-width helper.
package link_udc_bus_pack_pkg;

    localparam int UDC_W               = 16;
    localparam int MISS_W              = 2;
    localparam int LINK_W              = 5;
    localparam int LINKS_PER_PHASE_DEF = 24;

    typedef enum logic [1:0] {
        PHASE_A = 2'd0,
        PHASE_B = 2'd1,
        PHASE_C = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY_A,
        S_COPY_B,
        S_COPY_C
    } state_e;

    // Width of one phase bus: one UDC_W word per link
    function automatic int busWidth(input int links);
        return links * UDC_W;
    endfunction

endpackage

// File: rtl/link_udc_bus_pack_phase_udc_slot.sv
// One phase worth of link storage: shadow Udc words, fresh flags and miss
// counters, plus the combinational masked bus and live-link count that the
// top registers when this phase is copied.
module phase_udc_slot
    import link_udc_bus_pack_pkg::*;
#(
    parameter int LINKS    = LINKS_PER_PHASE_DEF,
    parameter int MISS_MAX = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrEn,
    input  logic [LINK_W-1:0]          wrLink,
    input  logic [UDC_W-1:0]           wrUdc,
    input  logic                       copyStb,
    output logic [busWidth(LINKS)-1:0] busNext,
    output logic [15:0]                countNext
);

    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

    logic [LINKS-1:0][UDC_W-1:0]  shadow;
    logic [LINKS-1:0]             fresh;
    logic [LINKS-1:0][MISS_W-1:0] miss;
    logic [LINKS-1:0][MISS_W-1:0] newMiss;

    // Miss value each link takes on a copy, and the bus/count that follows from it
    always_comb begin
        newMiss   = '0;
        busNext   = '0;
        countNext = '0;
        for (int unsigned k = 0; k < LINKS; k++) begin
            if (fresh[k]) begin
                newMiss[k] = '0;
            end else if (miss[k] >= MISS_LIM) begin
                newMiss[k] = MISS_LIM;
            end else begin
                newMiss[k] = miss[k] + 1'b1;
            end
            if (newMiss[k] < MISS_LIM) begin
                busNext[k*UDC_W +: UDC_W] = shadow[k];
                countNext                 = countNext + 16'd1;
            end
        end
    end

    // Shadow storage update; a write is placed after the copy so it would win a tie
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            fresh  <= '0;
            for (int unsigned k = 0; k < LINKS; k++) begin
                miss[k] <= MISS_LIM;
            end
        end else begin
            if (copyStb) begin
                miss  <= newMiss;
                fresh <= '0;
            end
            for (int unsigned k = 0; k < LINKS; k++) begin
                if (wrEn && (wrLink == LINK_W'(k))) begin
                    shadow[k] <= wrUdc;
                    fresh[k]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/link_udc_bus_pack.sv
// Producer side of the per-phase link-Udc buses. Collects per-link reports
// into three phase slots and publishes A, B, C snapshots on request.
// Optional feature macro: UDC_RANGE_CHECK_EN (drop reports above UDC_MAX).
module link_udc_bus_pack
    import link_udc_bus_pack_pkg::*;
#(
    parameter int          LINKS_PER_PHASE = LINKS_PER_PHASE_DEF,
    parameter int          MISS_MAX        = 3,
    parameter logic [15:0] UDC_MAX         = 16'hFFF0
) (
    input  logic                                 i_clk_20M,
    input  logic                                 i_reset,
    input  logic                                 i_wr_valid,
    output logic                                 o_wr_ready,
    input  logic [1:0]                           i_wr_phase,
    input  logic [4:0]                           i_wr_link,
    input  logic [15:0]                          i_wr_udc,
    output logic                                 o_wr_err,
    input  logic                                 i_snap_req,
    output logic [busWidth(LINKS_PER_PHASE)-1:0] o_LinkUdcA_BUS,
    output logic [busWidth(LINKS_PER_PHASE)-1:0] o_LinkUdcB_BUS,
    output logic [busWidth(LINKS_PER_PHASE)-1:0] o_LinkUdcC_BUS,
    output logic [15:0]                          o_LinkNumA_Work,
    output logic [15:0]                          o_LinkNumB_Work,
    output logic [15:0]                          o_LinkNumC_Work,
    output logic                                 o_snap_done,
    output logic                                 o_snap_overrun
);

    localparam int BW = busWidth(LINKS_PER_PHASE);

    state_e          state;
    logic            accept;
    logic            idxOk;
    logic            udcOk;
    logic            goodWr;
    logic [2:0]      wrEn;
    logic [2:0]      copyStb;
    logic [BW-1:0]   busNextA, busNextB, busNextC;
    logic [15:0]     cntNextA, cntNextB, cntNextC;

    assign o_wr_ready = (state == S_IDLE) && !i_reset;
    assign accept     = i_wr_valid && o_wr_ready;
    assign idxOk      = (i_wr_phase != 2'd3) && (32'(i_wr_link) < LINKS_PER_PHASE);

`ifdef UDC_RANGE_CHECK_EN
    assign udcOk = (i_wr_udc <= UDC_MAX);
`else
    // Range limit disabled: every in-index value is stored (the OR keeps UDC_MAX referenced)
    assign udcOk = 1'b1 | (i_wr_udc <= UDC_MAX);
`endif

    assign goodWr = accept && idxOk && udcOk;

    // Route an accepted in-range write to its phase, and the copy strobe per state
    always_comb begin
        wrEn       = '0;
        wrEn[0]    = goodWr && (i_wr_phase == PHASE_A);
        wrEn[1]    = goodWr && (i_wr_phase == PHASE_B);
        wrEn[2]    = goodWr && (i_wr_phase == PHASE_C);
        copyStb    = '0;
        copyStb[0] = (state == S_COPY_A);
        copyStb[1] = (state == S_COPY_B);
        copyStb[2] = (state == S_COPY_C);
    end

    phase_udc_slot #(.LINKS(LINKS_PER_PHASE), .MISS_MAX(MISS_MAX)) slotA (
        .clk(i_clk_20M), .reset(i_reset), .wrEn(wrEn[0]), .wrLink(i_wr_link),
        .wrUdc(i_wr_udc), .copyStb(copyStb[0]), .busNext(busNextA), .countNext(cntNextA)
    );

    phase_udc_slot #(.LINKS(LINKS_PER_PHASE), .MISS_MAX(MISS_MAX)) slotB (
        .clk(i_clk_20M), .reset(i_reset), .wrEn(wrEn[1]), .wrLink(i_wr_link),
        .wrUdc(i_wr_udc), .copyStb(copyStb[1]), .busNext(busNextB), .countNext(cntNextB)
    );

    phase_udc_slot #(.LINKS(LINKS_PER_PHASE), .MISS_MAX(MISS_MAX)) slotC (
        .clk(i_clk_20M), .reset(i_reset), .wrEn(wrEn[2]), .wrLink(i_wr_link),
        .wrUdc(i_wr_udc), .copyStb(copyStb[2]), .busNext(busNextC), .countNext(cntNextC)
    );

    // Publish sequencer with registered buses, counts and status pulses
    always_ff @(posedge i_clk_20M) begin
        if (i_reset) begin
            state           <= S_IDLE;
            o_LinkUdcA_BUS  <= '0;
            o_LinkUdcB_BUS  <= '0;
            o_LinkUdcC_BUS  <= '0;
            o_LinkNumA_Work <= '0;
            o_LinkNumB_Work <= '0;
            o_LinkNumC_Work <= '0;
            o_wr_err        <= 1'b0;
            o_snap_done     <= 1'b0;
            o_snap_overrun  <= 1'b0;
        end else begin
            o_wr_err       <= accept && !(idxOk && udcOk);
            o_snap_done    <= 1'b0;
            o_snap_overrun <= i_snap_req && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_snap_req) begin
                        state <= S_COPY_A;
                    end
                end
                S_COPY_A: begin
                    o_LinkUdcA_BUS  <= busNextA;
                    o_LinkNumA_Work <= cntNextA;
                    state           <= S_COPY_B;
                end
                S_COPY_B: begin
                    o_LinkUdcB_BUS  <= busNextB;
                    o_LinkNumB_Work <= cntNextB;
                    state           <= S_COPY_C;
                end
                S_COPY_C: begin
                    o_LinkUdcC_BUS  <= busNextC;
                    o_LinkNumC_Work <= cntNextC;
                    o_snap_done     <= 1'b1;
                    state           <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
